// File: rtl/hcsr04_pkg.sv
// Shared constants and FSM encoding for the HC-SR04 ranger driver.
package hcsr04_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_MEAS  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CLK_HZ_DEF     = 50_000_000;
  localparam int TRIG_US_DEF    = 10;
  localparam int TIMEOUT_US_DEF = 38000;
  localparam int US_PER_CM_DEF  = 58;

  localparam int CYC_US_DEF      = CLK_HZ_DEF / 1_000_000;
  localparam int TRIG_CYC_DEF    = TRIG_US_DEF * CYC_US_DEF;
  localparam int TIMEOUT_CYC_DEF = TIMEOUT_US_DEF * CYC_US_DEF;

  localparam logic [15:0] LEN_MAX = 16'hFFFF;

endpackage

// File: rtl/hcsr04_prescaler.sv
// Clear-able tick generator: o_tick fires on every N-th cycle after i_clr drops.
module hcsr04_prescaler #(
  parameter int N = 50
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || r_cnt == '0) begin
      r_cnt <= W'(N - 1);
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = ~i_clr && (r_cnt == '0);

endmodule

// File: rtl/hcsr04_ctrl.sv
// HC-SR04 driver: trigger pulse, echo width measurement, 16-bit result.
// Define HCSR04_CM_EN to report len in whole cm instead of whole us.
module hcsr04_ctrl
  import hcsr04_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int TRIG_US    = TRIG_US_DEF,
  parameter int TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int US_PER_CM  = US_PER_CM_DEF
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_len,
  output logic        sig_trig,
  output logic [15:0] len,
  output logic        done
);

`ifdef HCSR04_CM_EN
  localparam bit CM_EN = 1'b1;
`else
  localparam bit CM_EN = 1'b0;
`endif

  localparam int CYC_US      = CLK_HZ / 1_000_000;
  localparam int TRIG_CYC    = TRIG_US * CYC_US;
  localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_US;
  localparam int UNIT        = CM_EN ? CYC_US * US_PER_CM : CYC_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  state_t        r_state;
  logic [1:0]    r_sync;
  logic          r_echo_d;
  logic [TW-1:0] r_tmr;
  logic [15:0]   r_cnt;
  logic          w_rise;
  logic          w_fall;
  logic          w_accept;
  logic          w_tick;
  logic [15:0]   w_cnt_nxt;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_sync   <= 2'b00;
      r_echo_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], sig_len};
      r_echo_d <= r_sync[1];
    end
  end

  assign w_rise   = r_sync[1] & ~r_echo_d;
  assign w_fall   = ~r_sync[1] & r_echo_d;
  assign w_accept = (r_state == ST_IDLE) && en;

  // One down-counter serves both the trigger width and the echo timeout;
  // the trigger is high while the counter is within its first TRIG_CYC counts.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_tmr    <= '0;
      sig_trig <= 1'b0;
    end else if (w_accept) begin
      r_tmr    <= TW'(TIMEOUT_CYC - 1);
      sig_trig <= 1'b1;
    end else begin
      if (r_tmr != '0) r_tmr <= r_tmr - 1'b1;
      sig_trig <= (r_tmr > TW'(TIMEOUT_CYC - TRIG_CYC));
    end
  end

  hcsr04_prescaler #(.N(UNIT)) u_presc (
    .i_clk  (clk50M),
    .i_rst  (rst),
    .i_clr  (r_state != ST_MEAS),
    .o_tick (w_tick)
  );

  // A tick landing on the fall cycle still counts, giving floor(width/unit).
  assign w_cnt_nxt = (w_tick && r_cnt != LEN_MAX) ? r_cnt + 16'd1 : r_cnt;

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      len     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (w_rise) begin
            r_cnt   <= '0;
            r_state <= ST_MEAS;
          end else if (r_tmr == '0) begin
            len     <= LEN_MAX;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_MEAS: begin
          r_cnt <= w_cnt_nxt;
          if (w_fall || w_cnt_nxt == LEN_MAX) begin
            len     <= w_cnt_nxt;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_ctrl.sv
// Scoreboard bench for hcsr04_ctrl, run at a reduced clock and timeout.
`timescale 1ns/1ps
module tb_hcsr04_ctrl;

  localparam int CLK_HZ      = 2_000_000;
  localparam int TIMEOUT_US  = 8000;
  localparam int TRIG_CYC    = 20;
  localparam int TIMEOUT_CYC = 16000;

`ifdef HCSR04_CM_EN
  localparam logic [15:0] E1 = 16'd100, E2 = 16'd23, E3 = 16'd40, E4 = 16'd17, E7 = 16'd8;
`else
  localparam logic [15:0] E1 = 16'd5800, E2 = 16'd1344, E3 = 16'd2334, E4 = 16'd999, E7 = 16'd500;
`endif

  logic        clk50M = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        sig_len = 1'b0;
  logic        sig_trig;
  logic [15:0] len;
  logic        done;

  int n_tests = 0, n_fail = 0;
  int n_done = 0, n_done_exp = 0;
  int n_trig = 0, n_trig_exp = 0;
  int tw = 0;
  logic [15:0] q_len[$];

  always #250 clk50M = ~clk50M;

  hcsr04_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) dut (
    .clk50M   (clk50M),
    .rst      (rst),
    .en       (en),
    .sig_len  (sig_len),
    .sig_trig (sig_trig),
    .len      (len),
    .done     (done)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: every done pops one expected length.
  always @(negedge clk50M) begin
    if (!rst && done) begin
      n_done++;
      if (q_len.size() == 0) check("unexpected_done", 1, 0);
      else check("len", int'(len), int'(q_len.pop_front()));
    end
  end

  // Trigger monitor: every completed pulse must be TRIG_CYC cycles wide.
  always @(negedge clk50M) begin
    if (rst) tw = 0;
    else if (sig_trig) tw++;
    else if (tw > 0) begin
      n_trig++;
      check("trig_width", tw, TRIG_CYC);
      tw = 0;
    end
  end

  task automatic pulse_en(input int n);
    en = 1'b1;
    repeat (n) @(negedge clk50M);
    en = 1'b0;
    n_trig_exp++;
  endtask

  task automatic echo(input int delay_cyc, input int width_cyc, input logic [15:0] exp);
    int n0;
    int c;
    q_len.push_back(exp);
    n_done_exp++;
    repeat (delay_cyc) @(negedge clk50M);
    sig_len = 1'b1;
    repeat (width_cyc) @(negedge clk50M);
    n0 = n_done;
    sig_len = 1'b0;
    c = 0;
    while (n_done == n0 && c < 12) begin
      @(negedge clk50M);
      #1;
      c++;
    end
    check("done_latency", c, 3);
    repeat (10) @(negedge clk50M);
  endtask

  initial begin
    int c;
    int n0;
    #10 rst = 1'b1;
    #20;
    check("rst_len", int'(len), 0);
    check("rst_done", int'(done), 0);
    check("rst_trig", int'(sig_trig), 0);
    repeat (3) @(negedge clk50M);
    rst = 1'b0;
    repeat (5) @(negedge clk50M);

    // 1: en held two cycles, echo shortly after
    pulse_en(2);
    echo(1, 11600, E1);

    // 2: echo rises during the trigger; en pulsed mid-measurement is ignored
    pulse_en(1);
    fork
      echo(8, 2688, E2);
      begin
        repeat (500) @(negedge clk50M);
        en = 1'b1;
        @(negedge clk50M);
        en = 1'b0;
      end
    join

    // 3 and 4: later echo rises
    pulse_en(1);
    echo(60, 4668, E3);
    pulse_en(1);
    echo(20, 1998, E4);

    // 7: echo already high when started, must wait for a fresh rise
    sig_len = 1'b1;
    repeat (4) @(negedge clk50M);
    pulse_en(1);
    repeat (10) @(negedge clk50M);
    sig_len = 1'b0;
    repeat (10) @(negedge clk50M);
    echo(0, 1000, E7);

    // 5: no echo -> timeout, en during ARMED ignored
    q_len.push_back(16'hFFFF);
    n_done_exp++;
    pulse_en(1);
    n0 = n_done;
    c = 0;
    while (n_done == n0 && c < TIMEOUT_CYC + 100) begin
      @(negedge clk50M);
      if (c == 100) en = 1'b1;
      else en = 1'b0;
      #1;
      c++;
    end
    en = 1'b0;
    check("timeout_cycles", c, TIMEOUT_CYC);
    repeat (10) @(negedge clk50M);

    // 6: reset mid-measurement while trigger is still high
    pulse_en(1);
    n_trig_exp--;
    repeat (3) @(negedge clk50M);
    sig_len = 1'b1;
    repeat (8) @(negedge clk50M);
    #100 rst = 1'b1;
    #1;
    check("rst_mid_trig", int'(sig_trig), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_len", int'(len), 0);
    repeat (2) @(negedge clk50M);
    rst = 1'b0;
    repeat (20) @(negedge clk50M);
    sig_len = 1'b0;
    repeat (50) @(negedge clk50M);

    check("queue_empty", q_len.size(), 0);
    check("done_count", n_done, n_done_exp);
    check("trig_count", n_trig, n_trig_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #40_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
